// File: rtl/ringcounter_jerky_monitor.sv
// ringcounter_jerky_monitor: checks the jerky ring counter's one-hot stream (1, 1<<k, 1, 1<<(k+1), ...)
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid, in_data  sampled one-hot word (no backpressure)
//   clr_err            synchronous clear of err_cnt
//   idx_out/idx_valid  binary index of the last valid one-hot word / update pulse
//   onehot_err         pulse: sampled word was zero or multi-hot
//   seq_err            pulse: sequence break while locked
//   locked             high while tracking in LOCK
//   err_cnt            saturating count of seq_err events
module ringcounter_jerky_monitor #(
   parameter int BW     = 8,
   parameter int LOCK_N = 2,
   parameter int CW     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [BW-1:0]         in_data,
   input  logic                  clr_err,
   output logic [$clog2(BW)-1:0] idx_out,
   output logic                  idx_valid,
   output logic                  onehot_err,
   output logic                  seq_err,
   output logic                  locked,
   output logic [CW-1:0]         err_cnt
);
   localparam int IW = $clog2(BW);
   localparam int MW = $clog2(LOCK_N + 1);
   typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;
   state_t state, state_nx;
   logic exp_probe, exp_probe_nx;
   logic [IW-1:0] exp_k, exp_k_nx, idx;
   logic [MW-1:0] match_cnt, match_cnt_nx;
   logic [BW-1:0] exp_word;
   logic onehot, match, seq_hit;
   // exp_k is the probe position that follows the expected base word
   function automatic logic [IW-1:0] next_k(input logic [IW-1:0] k);
      return (k == IW'(BW - 1)) ? IW'(1) : k + IW'(1);
   endfunction
   always_comb begin
      idx = '0;
      for (int i = 0; i < BW; i++)
         if (in_data[i]) idx = IW'(i);
   end
   assign onehot   = (in_data != '0) && ((in_data & (in_data - BW'(1))) == '0);
   assign exp_word = exp_probe ? (BW'(1) << exp_k) : BW'(1);
   assign match    = onehot && (in_data == exp_word);
   assign locked   = (state == LOCK);
   always_comb begin
      state_nx     = state;
      exp_probe_nx = exp_probe;
      exp_k_nx     = exp_k;
      match_cnt_nx = match_cnt;
      seq_hit      = 1'b0;
      if (in_valid) begin
         case (state)
            HUNT: if (onehot && idx != '0) begin
               state_nx     = ACQ;
               exp_probe_nx = 1'b0;
               exp_k_nx     = next_k(idx);
               match_cnt_nx = '0;
            end
            ACQ: if (match) begin
               exp_probe_nx = ~exp_probe;
               exp_k_nx     = exp_probe ? next_k(exp_k) : exp_k;
               match_cnt_nx = match_cnt + MW'(1);
               state_nx     = (match_cnt_nx == MW'(LOCK_N)) ? LOCK : ACQ;
            end else state_nx = HUNT;
            LOCK: if (match) begin
               exp_probe_nx = ~exp_probe;
               exp_k_nx     = exp_probe ? next_k(exp_k) : exp_k;
            end else begin
               seq_hit  = 1'b1;
               state_nx = HUNT;
            end
            default: state_nx = HUNT;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         exp_probe  <= 1'b0;
         exp_k      <= IW'(1);
         match_cnt  <= '0;
         idx_out    <= '0;
         idx_valid  <= 1'b0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state      <= state_nx;
         exp_probe  <= exp_probe_nx;
         exp_k      <= exp_k_nx;
         match_cnt  <= match_cnt_nx;
         idx_valid  <= in_valid && onehot;
         onehot_err <= in_valid && !onehot;
         seq_err    <= seq_hit;
         if (in_valid && onehot) idx_out <= idx;
         err_cnt    <= clr_err ? '0 : (seq_hit && err_cnt != '1) ? err_cnt + CW'(1) : err_cnt;
      end
   end
endmodule

// File: tb/tb_ringcounter_jerky_monitor.sv
// tb_ringcounter_jerky_monitor: scoreboard bench comparing the monitor against a sequence-list reference model
module tb_ringcounter_jerky_monitor;
   localparam int BW = 4, LOCK_N = 2, CW = 2, L = 2 * (BW - 1);
   logic clk = 0, rst = 0, in_valid = 0, clr_err = 0;
   logic [BW-1:0] in_data = '0;
   logic [1:0] idx_out;
   logic idx_valid, onehot_err, seq_err, locked;
   logic [CW-1:0] err_cnt;
   logic [7:0] q[$];
   int total = 0, bad = 0;
   int seq_w[L];
   int mode = 0, pos = 0, hits = 0, errs = 0, last_idx = 0;
   always #5 clk = ~clk;
   ringcounter_jerky_monitor #(.BW(BW), .LOCK_N(LOCK_N), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
      .idx_out(idx_out), .idx_valid(idx_valid), .onehot_err(onehot_err),
      .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
   );
   task automatic check(string name, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask
   // mode: 0 hunting, 1 acquiring, 2 locked; pos = index in seq_w of the last accepted word
   task automatic model(bit v, int d, bit clr);
      bit ok1, se;
      ok1 = $countones(d) == 1;
      se = 0;
      if (v) begin
         if (ok1) last_idx = $clog2(d);
         if (mode == 0) begin
            if (ok1 && d != 1) begin
               mode = 1;
               pos = 2 * ($clog2(d) - 1);
               hits = 0;
            end
         end else if (d == seq_w[(pos + 1) % L]) begin
            pos = (pos + 1) % L;
            hits++;
            if (mode == 1 && hits == LOCK_N) mode = 2;
         end else begin
            se = (mode == 2);
            mode = 0;
         end
      end
      if (clr) errs = 0;
      else if (se && errs < (1 << CW) - 1) errs++;
      q.push_back({2'(last_idx), v && ok1, v && !ok1, se, mode == 2, 2'(errs)});
   endtask
   task automatic step(bit v, int d, bit clr = 0);
      @(negedge clk);
      in_valid = v;
      in_data = BW'(d);
      clr_err = clr;
      model(v, d, clr);
   endtask
   task automatic settle();
      @(posedge clk);
      #2;
   endtask
   task automatic relock();
      step(1, 2); step(1, 1); step(1, 4);
   endtask
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("scoreboard", {idx_out, idx_valid, onehot_err, seq_err, locked, err_cnt}, e);
         end
      end
   end
   initial begin
      int g;
      bit v, c;
      int d;
      for (int i = 0; i < L; i++) seq_w[i] = (i % 2 == 0) ? (1 << (i / 2 + 1)) : 1;
      rst = 1;
      #1;
      check("reset_outs", {idx_out, idx_valid, onehot_err, seq_err, locked, err_cnt}, 0);
      @(negedge clk);
      rst = 0;
      foreach (seq_w[i]) if (i < 0) $display("unreachable");
      step(1, 1); step(1, 1); step(1, 2); step(1, 1); step(1, 4);
      settle();
      check("t1_locked_after_4", locked, 1);
      step(1, 1); step(1, 8); step(1, 1); step(1, 2);
      settle();
      check("t2_wrap_locked", locked, 1);
      check("t1_idx", idx_out, 1);
      step(1, 1); step(1, 4); step(1, 1); step(1, 8); step(1, 1); step(1, 4);
      settle();
      check("t2_seq_err", seq_err, 1);
      check("t2_err_cnt", err_cnt, 1);
      check("t2_unlocked", locked, 0);
      step(1, 6); step(1, 0);
      settle();
      check("t3_hunt_err_cnt", err_cnt, 1);
      relock();
      step(1, 6);
      settle();
      check("t3_lock_both", {onehot_err, seq_err}, 3);
      relock(); step(1, 2);
      relock(); step(1, 2);
      relock(); step(1, 2);
      settle();
      check("t4_saturated", err_cnt, 3);
      relock(); step(1, 2, 1);
      settle();
      check("t4_clr_wins", err_cnt, 0);
      relock();
      step(0, 8); step(0, 2); step(0, 15);
      settle();
      check("t5_idle_locked", locked, 1);
      step(1, 1); step(1, 8); step(1, 1); step(1, 2);
      settle();
      check("t5_resume", {locked, err_cnt}, 4);
      relock(); step(1, 2);
      relock(); step(1, 2);
      relock();
      settle();
      check("t6_pre_cnt", err_cnt, 2);
      @(negedge clk);
      rst = 1;
      in_valid = 0;
      #1;
      check("t6_rst_immediate", {idx_out, idx_valid, onehot_err, seq_err, locked, err_cnt}, 0);
      @(negedge clk);
      rst = 0;
      mode = 0; pos = 0; hits = 0; errs = 0; last_idx = 0;
      step(1, 1); step(1, 2);
      settle();
      check("t6_acq_not_lock", locked, 0);
      step(1, 1); step(1, 4);
      settle();
      check("t6_relock", locked, 1);
      g = 0;
      for (int n = 0; n < 400; n++) begin
         v = $urandom_range(0, 9) != 0;
         d = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : seq_w[g];
         if (v) g = (g + 1) % L;
         if ($urandom_range(0, 30) == 0) g = int'($urandom_range(0, L - 1));
         c = $urandom_range(0, 19) == 0;
         step(v, d, c);
      end
      step(0, 0);
      repeat (3) @(posedge clk);
      #2;
      check("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
